// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM states and port indices.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} arb_state_t;

  typedef logic port_t;
  localparam port_t PORT_D  = 1'b0;
  localparam port_t PORT_IF = 1'b1;

  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester (fetch, data) and memory-side signals around mem_arbiter.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  import mem_arbiter_pkg::*;

  logic                if_valid;
  logic                if_ready;
  logic [ADDR_W-1:0]   if_addr;
  logic                if_rvalid;
  logic [DATA_W-1:0]   if_rdata;
  logic                if_err;

  logic                d_valid;
  logic                d_ready;
  logic [ADDR_W-1:0]   d_addr;
  logic                d_we;
  logic [STRB_W-1:0]   d_wstrb;
  logic [DATA_W-1:0]   d_wdata;
  logic                d_rvalid;
  logic [DATA_W-1:0]   d_rdata;
  logic                d_err;

  logic                mem_req;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_we;
  logic [STRB_W-1:0]   mem_wstrb;
  logic [DATA_W-1:0]   mem_wdata;
  logic                mem_gnt;
  logic                mem_rvalid;
  logic [DATA_W-1:0]   mem_rdata;

  modport slave (
    input  if_valid, if_addr,
    output if_ready, if_rvalid, if_rdata, if_err,
    input  d_valid, d_addr, d_we, d_wstrb, d_wdata,
    output d_ready, d_rvalid, d_rdata, d_err,
    output mem_req, mem_addr, mem_we, mem_wstrb, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport master (
    output if_valid, if_addr,
    input  if_ready, if_rvalid, if_rdata, if_err,
    output d_valid, d_addr, d_we, d_wstrb, d_wdata,
    input  d_ready, d_rvalid, d_rdata, d_err,
    input  mem_req, mem_addr, mem_we, mem_wstrb, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational two-way winner select: a lone requester wins; on a tie the port not granted last wins.
module arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic  valid_d,
  input  logic  valid_if,
  input  port_t last,
  output logic  any,
  output port_t winner
);

  always_comb begin
    winner = PORT_D;
    if (valid_d && valid_if)
      winner = (last == PORT_D) ? PORT_IF : PORT_D;
    else if (valid_if)
      winner = PORT_IF;
  end

  assign any = valid_d | valid_if;

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter onto a single-port memory, one transaction in flight, with response timeout.
// Define MEM_ARBITER_RR_EN for round-robin arbitration; otherwise the data port has fixed priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  arb_state_t           state, state_nx;
  port_t                port_r, winner, last;
  logic                 any, accept, timeout;
  logic [ADDR_W-1:0]    addr_r;
  logic                 we_r;
  logic [STRB_W-1:0]    wstrb_r;
  logic [DATA_W-1:0]    wdata_r, rdata_r;
  logic                 err_r;
  logic [CNT_W-1:0]     cnt_r, cnt_inc;
  logic                 d_rvalid, if_rvalid;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c >= CNT_W'(TIMEOUT)) ? c : c + 1'b1;
  endfunction

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return a & ~ADDR_W'(3);
  endfunction

`ifdef MEM_ARBITER_RR_EN
  port_t last_r;
  // Reset value points at the fetch port so the data port wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       last_r <= PORT_IF;
    else if (accept) last_r <= winner;
  end
  assign last = last_r;
`else
  assign last = PORT_IF;
`endif

  arb_pick u_pick (
    .valid_d  (bus.d_valid),
    .valid_if (bus.if_valid),
    .last     (last),
    .any      (any),
    .winner   (winner)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    timeout  = 1'b0;
    cnt_inc  = sat_inc(cnt_r);
    case (state)
      IDLE: if (any && !reset) begin
        accept   = 1'b1;
        state_nx = REQ;
      end
      REQ:  if (bus.mem_gnt) state_nx = WAIT;
      WAIT: begin
        if (bus.mem_rvalid) begin
          state_nx = RESP;
        end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
          timeout  = 1'b1;
          state_nx = RESP;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      port_r  <= PORT_D;
      addr_r  <= '0;
      we_r    <= 1'b0;
      wstrb_r <= '0;
      wdata_r <= '0;
      rdata_r <= '0;
      err_r   <= 1'b0;
      cnt_r   <= '0;
    end else begin
      if (accept) begin
        port_r <= winner;
        if (winner == PORT_D) begin
          addr_r  <= word_align(bus.d_addr);
          we_r    <= bus.d_we;
          wstrb_r <= bus.d_wstrb;
          wdata_r <= bus.d_wdata;
        end else begin
          addr_r  <= word_align(bus.if_addr);
          we_r    <= 1'b0;
          wstrb_r <= '0;
          wdata_r <= '0;
        end
      end
      if (state == REQ && bus.mem_gnt) cnt_r <= '0;
      else if (state == WAIT)          cnt_r <= cnt_inc;
      // Stores complete with zero read data; a timeout reports an error with zero data.
      if (state == WAIT && bus.mem_rvalid) begin
        rdata_r <= we_r ? '0 : bus.mem_rdata;
        err_r   <= 1'b0;
      end else if (timeout) begin
        rdata_r <= '0;
        err_r   <= 1'b1;
      end
    end
  end

  assign d_rvalid  = (state == RESP) && (port_r == PORT_D);
  assign if_rvalid = (state == RESP) && (port_r == PORT_IF);

  assign bus.d_ready   = accept && (winner == PORT_D);
  assign bus.if_ready  = accept && (winner == PORT_IF);
  assign bus.d_rvalid  = d_rvalid;
  assign bus.if_rvalid = if_rvalid;
  assign bus.d_rdata   = rdata_r;
  assign bus.if_rdata  = rdata_r;
  assign bus.d_err     = d_rvalid && err_r;
  assign bus.if_err    = if_rvalid && err_r;

  assign bus.mem_req   = (state == REQ);
  assign bus.mem_addr  = addr_r;
  assign bus.mem_we    = (state == REQ) && we_r;
  assign bus.mem_wstrb = wstrb_r;
  assign bus.mem_wdata = wdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; tie-break expectations follow MEM_ARBITER_RR_EN.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .TIMEOUT(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Entered at a negedge with the DUT in REQ; returns at the negedge where RESP is visible.
  task automatic mem_serve(input int rv_wait, input logic [31:0] data);
    check("serve_mem_req", bus.mem_req, 1'b1);
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    bus.mem_gnt = 1'b0;
    repeat (rv_wait) @(negedge clk);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = data;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
  endtask

  initial begin
    logic first_d;
    int   n;

    bus.if_valid = 0; bus.if_addr = '0;
    bus.d_valid = 0; bus.d_addr = '0; bus.d_we = 0; bus.d_wstrb = '0; bus.d_wdata = '0;
    bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = '0;

    // Reset state, with a pending data request that must not be acknowledged.
    repeat (2) @(negedge clk);
    bus.d_valid = 1'b1; bus.d_addr = 32'h8; #1;
    check("rst_d_ready", bus.d_ready, 1'b0);
    check("rst_mem_req", bus.mem_req, 1'b0);
    check("rst_mem_we", bus.mem_we, 1'b0);
    check("rst_wstrb", bus.mem_wstrb, 4'h0);
    check("rst_rvalid", {bus.d_rvalid, bus.if_rvalid, bus.d_err, bus.if_err}, 4'h0);
    bus.d_valid = 1'b0; bus.d_addr = '0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Fetch-only read, 1-cycle memory.
    bus.if_valid = 1'b1; bus.if_addr = 32'h10; #1;
    check("f_if_ready", bus.if_ready, 1'b1);
    check("f_d_ready", bus.d_ready, 1'b0);
    @(negedge clk);
    bus.if_valid = 1'b0; bus.if_addr = '0;
    check("f_mem_addr", bus.mem_addr, 32'h10);
    check("f_mem_we", bus.mem_we, 1'b0);
    check("f_if_ready_req", bus.if_ready, 1'b0);
    mem_serve(0, 32'h00100093);
    check("f_if_rvalid", bus.if_rvalid, 1'b1);
    check("f_if_rdata", bus.if_rdata, 32'h00100093);
    check("f_if_err", bus.if_err, 1'b0);
    check("f_d_rvalid", bus.d_rvalid, 1'b0);
    @(negedge clk);
    check("f_if_rvalid_end", bus.if_rvalid, 1'b0);

    // Simultaneous requests: data wins the first tie in both modes.
    bus.d_valid = 1'b1; bus.d_addr = 32'h20; bus.d_we = 1'b0;
    bus.if_valid = 1'b1; bus.if_addr = 32'h14; #1;
    check("s1_d_ready", bus.d_ready, 1'b1);
    check("s1_if_ready", bus.if_ready, 1'b0);
    @(negedge clk);
    bus.d_valid = 1'b0;
    check("s1_mem_addr", bus.mem_addr, 32'h20);
    check("s1_if_ready_req", bus.if_ready, 1'b0);
    mem_serve(0, 32'h11111111);
    check("s1_d_rvalid", bus.d_rvalid, 1'b1);
    check("s1_d_rdata", bus.d_rdata, 32'h11111111);
    check("s1_if_rvalid", bus.if_rvalid, 1'b0);
    @(negedge clk);
    // Second tie: fixed priority picks data again, round-robin picks fetch.
`ifdef MEM_ARBITER_RR_EN
    first_d = 1'b0;
`else
    first_d = 1'b1;
`endif
    bus.d_valid = 1'b1; bus.d_addr = 32'h24; #1;
    check("s2_d_ready", bus.d_ready, first_d);
    check("s2_if_ready", bus.if_ready, !first_d);
    @(negedge clk);
    if (first_d) bus.d_valid = 1'b0; else bus.if_valid = 1'b0;
    check("s2_mem_addr", bus.mem_addr, first_d ? 32'h24 : 32'h14);
    mem_serve(0, 32'h33333333);
    check("s2_d_rvalid", bus.d_rvalid, first_d);
    check("s2_if_rvalid", bus.if_rvalid, !first_d);
    check("s2_rdata", first_d ? bus.d_rdata : bus.if_rdata, 32'h33333333);
    @(negedge clk); #1;
    check("s3_d_ready", bus.d_ready, !first_d);
    check("s3_if_ready", bus.if_ready, first_d);
    @(negedge clk);
    bus.d_valid = 1'b0; bus.if_valid = 1'b0;
    check("s3_mem_addr", bus.mem_addr, first_d ? 32'h14 : 32'h24);
    mem_serve(0, 32'h44444444);
    check("s3_d_rvalid", bus.d_rvalid, !first_d);
    check("s3_if_rvalid", bus.if_rvalid, first_d);
    check("s3_rdata", first_d ? bus.if_rdata : bus.d_rdata, 32'h44444444);
    @(negedge clk);

    // Misaligned store.
    bus.d_valid = 1'b1; bus.d_addr = 32'h43; bus.d_we = 1'b1;
    bus.d_wstrb = 4'b0011; bus.d_wdata = 32'hDEADBEEF; #1;
    check("st_d_ready", bus.d_ready, 1'b1);
    @(negedge clk);
    bus.d_valid = 1'b0; bus.d_we = 1'b0; bus.d_wstrb = '0; bus.d_wdata = '0; bus.d_addr = '0;
    check("st_mem_addr", bus.mem_addr, 32'h40);
    check("st_mem_we", bus.mem_we, 1'b1);
    check("st_mem_wstrb", bus.mem_wstrb, 4'b0011);
    check("st_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    mem_serve(0, 32'hCAFEF00D);
    check("st_d_rvalid", bus.d_rvalid, 1'b1);
    check("st_d_rdata", bus.d_rdata, 32'h0);
    check("st_d_err", bus.d_err, 1'b0);
    @(negedge clk);

    // Timeout: memory grants but never completes.
    bus.d_valid = 1'b1; bus.d_addr = 32'h80; #1;
    check("to_d_ready", bus.d_ready, 1'b1);
    @(negedge clk);
    bus.d_valid = 1'b0;
    check("to_mem_req", bus.mem_req, 1'b1);
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    bus.mem_gnt = 1'b0;
    n = 0;
    while (!bus.d_rvalid && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("to_wait_cycles", n, 15);
    check("to_d_rvalid", bus.d_rvalid, 1'b1);
    check("to_d_err", bus.d_err, 1'b1);
    check("to_d_rdata", bus.d_rdata, 32'h0);
    @(negedge clk);
    check("to_d_rvalid_end", bus.d_rvalid, 1'b0);
    bus.if_valid = 1'b1; bus.if_addr = 32'h18; #1;
    check("to_next_ready", bus.if_ready, 1'b1);
    @(negedge clk);
    bus.if_valid = 1'b0;
    mem_serve(0, 32'h00000055);
    check("to_next_rdata", bus.if_rdata, 32'h55);
    check("to_next_err", bus.if_err, 1'b0);
    @(negedge clk);

    // Grant stall in REQ, then a slow memory response that must not time out.
    bus.if_valid = 1'b1; bus.if_addr = 32'h30; #1;
    check("sl_if_ready", bus.if_ready, 1'b1);
    @(negedge clk);
    bus.if_valid = 1'b0; bus.if_addr = '0;
    bus.d_valid = 1'b1; bus.d_addr = 32'h34; bus.d_we = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("sl_mem_req", bus.mem_req, 1'b1);
      check("sl_mem_addr", bus.mem_addr, 32'h30);
      check("sl_d_ready", bus.d_ready, 1'b0);
      @(negedge clk);
    end
    mem_serve(13, 32'h00000066);
    check("sl_if_rvalid", bus.if_rvalid, 1'b1);
    check("sl_if_err", bus.if_err, 1'b0);
    check("sl_if_rdata", bus.if_rdata, 32'h66);
    @(negedge clk); #1;
    check("sl_d_ready", bus.d_ready, 1'b1);
    @(negedge clk);
    bus.d_valid = 1'b0;
    check("sl_d_addr", bus.mem_addr, 32'h34);
    mem_serve(0, 32'h00000077);
    check("sl_d_rdata", bus.d_rdata, 32'h77);
    @(negedge clk);

    // Asynchronous reset while waiting for memory; the late completion is dropped.
    bus.if_valid = 1'b1; bus.if_addr = 32'h50;
    @(negedge clk);
    bus.if_valid = 1'b0; bus.mem_gnt = 1'b1;
    @(negedge clk);
    bus.mem_gnt = 1'b0;
    bus.d_valid = 1'b1; bus.d_addr = 32'h54; #1;
    check("rw_d_ready_wait", bus.d_ready, 1'b0);
    reset = 1'b1; #1;
    check("rw_mem_req", bus.mem_req, 1'b0);
    check("rw_ready", {bus.d_ready, bus.if_ready}, 2'b00);
    check("rw_rvalid", {bus.d_rvalid, bus.if_rvalid, bus.d_err, bus.if_err}, 4'h0);
    check("rw_mem_addr", bus.mem_addr, 32'h0);
    bus.d_valid = 1'b0; bus.d_addr = '0;
    @(negedge clk);
    reset = 1'b0;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h00000BAD;
    @(negedge clk);
    bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    for (int i = 0; i < 3; i++) begin
      check("rw_no_resp", {bus.if_rvalid, bus.d_rvalid, bus.mem_req}, 3'b000);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
